sr_cmd_gen: RTL and testbench

//   Command-side driver for a bank of downstream SR flip-flops: converts "set channel ch to value v"

---
 rtl/sr_cmd_gen.sv | 191 +++++++++++++++++++
 tb/tb_sr_cmd_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Converts "set channel ch to value v" requests into S/R pulses for an SR flop bank, with a shadow copy
// of every flop to skip redundant pulses. Define SRG_READBACK_CHECK_EN to verify q_fb after settling.
module sr_cmd_gen #(
  parameter int NCH     = 6,
  parameter int CHW     = 3,
  parameter int PULSE_W = 1,
  parameter int SETTLE  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [CHW-1:0] req_ch,
  input  logic           req_val,
  input  logic           req_force,
  output logic [NCH-1:0] s_out,
  output logic [NCH-1:0] r_out,
  input  logic [NCH-1:0] q_fb,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [NCH-1:0] shadow
);

  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PCW-1:0] PULSE_LOAD  = PCW'(PULSE_W - 1);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_NOP    = 3'd1;
  localparam logic [2:0] ST_DRIVE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           val_q, val_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [NCH-1:0] s_q, s_d;
  logic [NCH-1:0] r_q, r_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [NCH-1:0] shadow_q, shadow_d;
  logic [NCH-1:0] svalid_q, svalid_d;

  // Shifting a one past the top bit leaves an all-zero mask, which marks an invalid channel.
  logic [NCH-1:0] req_mask_s;
  logic [NCH-1:0] ch_mask_s;
  logic           req_inval_s;
  logic           req_redund_s;
  logic           chk_err_s;

  assign req_mask_s   = NCH'(1'b1) << req_ch;
  assign ch_mask_s    = NCH'(1'b1) << ch_q;
  assign req_inval_s  = ~|req_mask_s;
  assign req_redund_s = ~req_force & (|(req_mask_s & svalid_q & ~(shadow_q ^ {NCH{req_val}})));

`ifdef SRG_READBACK_CHECK_EN
  assign chk_err_s = (|(q_fb & ch_mask_s)) ^ val_q;
`else
  logic unused_q_fb_s;
  assign unused_q_fb_s = ^q_fb;
  assign chk_err_s     = 1'b0;
`endif

  // Next-state and output decode; done/err are registered on entry to NOP or CHECK.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    val_d    = val_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    s_d      = '0;
    r_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    shadow_d = shadow_q;
    svalid_d = svalid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          ch_d  = req_ch;
          val_d = req_val;
          if (req_inval_s) begin
            state_d = ST_NOP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (req_redund_s) begin
            state_d = ST_NOP;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            pcnt_d  = PULSE_LOAD;
            if (req_val) begin
              s_d = req_mask_s;
            end else begin
              r_d = req_mask_s;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NOP: begin
        state_d = ST_IDLE;
      end
      ST_DRIVE: begin
        if (pcnt_q == '0) begin
          if (SETTLE == 0) begin
            state_d = ST_CHECK;
            done_d  = 1'b1;
            err_d   = chk_err_s;
          end else begin
            state_d = ST_SETTLE;
            scnt_d  = SETTLE_LOAD;
          end
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
          s_d    = s_q;
          r_d    = r_q;
        end
      end
      ST_SETTLE: begin
        if (scnt_q == '0) begin
          state_d = ST_CHECK;
          done_d  = 1'b1;
          err_d   = chk_err_s;
        end else begin
          scnt_d = scnt_q - SCW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        // A failed readback leaves the shadow untrusted so the next request re-pulses.
        if (val_q) begin
          shadow_d = shadow_q | ch_mask_s;
        end else begin
          shadow_d = shadow_q & ~ch_mask_s;
        end
        if (err_q) begin
          svalid_d = svalid_q & ~ch_mask_s;
        end else begin
          svalid_d = svalid_q | ch_mask_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      val_q    <= 1'b0;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      svalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      val_q    <= val_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      svalid_q <= svalid_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign shadow    = shadow_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed self-checking bench for sr_cmd_gen; q_fb comes from an ideal SR flop model with an
// optional stuck-at-0 mask. Expectations follow SRG_READBACK_CHECK_EN when it is defined.
module tb_sr_cmd_gen;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_ch;
  logic       req_val;
  logic       req_force;
  logic [5:0] s_out;
  logic [5:0] r_out;
  logic [5:0] q_fb;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] shadow;

  logic [5:0] q_model;
  logic [5:0] stuck;
  int         checks;
  int         errors;

`ifdef SRG_READBACK_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  sr_cmd_gen #(.NCH(6), .CHW(3), .PULSE_W(1), .SETTLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ch    (req_ch),
    .req_val   (req_val),
    .req_force (req_force),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .shadow    (shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal SR flop bank fed by the DUT pulses.
  always @(posedge clk) begin
    if (rst) q_model <= 6'd0;
    else     q_model <= (q_model | s_out) & ~r_out;
  end
  assign q_fb = q_model & ~stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("sr_exclusive", 32'(s_out & r_out), 32'd0);
    check("one_channel", 32'($countones(s_out | r_out) <= 1), 32'd1);
    check("err_without_done", 32'(err & ~done), 32'd0);
  endtask

  task automatic run_full(input string tag, input logic [2:0] ch, input logic val, input logic frc,
                          input logic [5:0] exp_s, input logic [5:0] exp_r, input logic exp_err,
                          input logic [5:0] exp_shadow);
    req_valid = 1'b1; req_ch = ch; req_val = val; req_force = frc;
    check({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_ch = ~ch; req_val = ~val; req_force = 1'b0;
    check({tag, "_s_a1"}, 32'(s_out), 32'(exp_s));
    check({tag, "_r_a1"}, 32'(r_out), 32'(exp_r));
    check({tag, "_busy_a1"}, 32'({busy, req_ready, done}), 32'b100);
    tick();
    check({tag, "_pulse_off_a2"}, 32'(s_out | r_out), 32'd0);
    tick();
    check({tag, "_done_a3"}, 32'(done), 32'd0);
    tick();
    check({tag, "_done_a4"}, 32'(done), 32'd1);
    check({tag, "_err_a4"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, "_idle_a5"}, 32'({done, err, req_ready, busy}), 32'b0010);
    check({tag, "_shadow_a5"}, 32'(shadow), 32'(exp_shadow));
  endtask

  task automatic run_nop(input string tag, input logic [2:0] ch, input logic val, input logic frc,
                         input logic exp_err, input logic [5:0] exp_shadow);
    req_valid = 1'b1; req_ch = ch; req_val = val; req_force = frc;
    check({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, "_done_a1"}, 32'(done), 32'd1);
    check({tag, "_err_a1"}, 32'(err), 32'(exp_err));
    check({tag, "_nopulse_a1"}, 32'(s_out | r_out), 32'd0);
    check({tag, "_ready_a1"}, 32'(req_ready), 32'd0);
    tick();
    check({tag, "_idle_a2"}, 32'({done, req_ready}), 32'b01);
    check({tag, "_shadow_a2"}, 32'(shadow), 32'(exp_shadow));
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = 1'b0; req_ch = 3'd0; req_val = 1'b0; req_force = 1'b0; stuck = 6'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready_busy", 32'({req_ready, busy}), 32'b10);
    check("rst_pulses", 32'({s_out, r_out}), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);

    // First request per channel always pulses; repeat is skipped unless forced.
    run_full("ch2_set", 3'd2, 1'b1, 1'b0, 6'b000100, 6'b000000, 1'b0, 6'b000100);
    run_nop("ch2_redundant", 3'd2, 1'b1, 1'b0, 1'b0, 6'b000100);
    run_full("ch2_force", 3'd2, 1'b1, 1'b1, 6'b000100, 6'b000000, 1'b0, 6'b000100);
    run_full("ch3_clr", 3'd3, 1'b0, 1'b0, 6'b000000, 6'b001000, 1'b0, 6'b000100);
    run_nop("ch3_redundant", 3'd3, 1'b0, 1'b0, 1'b0, 6'b000100);

    // Stuck-at-0 readback on channel 4.
    stuck = 6'b010000;
    run_full("ch4_stuck", 3'd4, 1'b1, 1'b0, 6'b010000, 6'b000000, CHK_EN, 6'b010100);
    if (CHK_EN) begin
      run_full("ch4_retry", 3'd4, 1'b1, 1'b0, 6'b010000, 6'b000000, 1'b1, 6'b010100);
    end else begin
      run_nop("ch4_retry", 3'd4, 1'b1, 1'b0, 1'b0, 6'b010100);
    end
    stuck = 6'd0;

    // Invalid channels, including the first index past the bank.
    run_nop("ch7_invalid", 3'd7, 1'b1, 1'b0, 1'b1, 6'b010100);
    run_nop("ch6_invalid", 3'd6, 1'b0, 1'b1, 1'b1, 6'b010100);

    // Reset during DRIVE discards the request.
    req_valid = 1'b1; req_ch = 3'd0; req_val = 1'b1; req_force = 1'b0;
    tick();
    req_valid = 1'b0;
    check("mid_rst_pulse_a1", 32'(s_out), 32'b000001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_pulse_off", 32'({s_out, r_out}), 32'd0);
    check("mid_rst_idle", 32'({done, req_ready, busy}), 32'b010);
    check("mid_rst_shadow", 32'(shadow), 32'd0);
    tick();
    check("mid_rst_no_done", 32'(done), 32'd0);
    run_full("ch2_after_rst", 3'd2, 1'b1, 1'b0, 6'b000100, 6'b000000, 1'b0, 6'b000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
